// File: rtl/hpc1_or_arbiter_if.sv
// Request, randomness, gadget and response signals of the HPC1 OR arbiter.
// The arbiter connects through the slave modport; requesters, the
// randomness source and the gadget together form the master side.
interface hpc1_or_arbiter_if #(
    parameter int SEC_ORDER = 2,
    parameter int NREQ      = 4,
    parameter int RND_W     = 6
);
    localparam int D = SEC_ORDER + 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*D-1:0] req_a;
    logic [NREQ*D-1:0] req_b;
    logic              rnd_valid;
    logic [RND_W-1:0]  rnd_in;
    logic              rnd_ready;
    logic              drain;
    logic              idle;
    logic [D-1:0]      g_ina;
    logic [D-1:0]      g_inb;
    logic [RND_W-1:0]  g_rnd;
    logic [D-1:0]      g_out;
    logic [NREQ-1:0]   rsp_valid;
    logic [D-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, req_b, rnd_valid, rnd_in, drain, g_out,
        input  req_ready, rnd_ready, idle, g_ina, g_inb, g_rnd, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rnd_valid, rnd_in, drain, g_out,
        output req_ready, rnd_ready, idle, g_ina, g_inb, g_rnd, rsp_valid, rsp_data
    );
endinterface

// File: rtl/hpc1_or_arbiter.sv
// Round-robin arbiter sharing one pipelined HPC1 masked-OR gadget between
// NREQ requesters. Shares and randomness pass through untouched; the
// arbiter never recombines shares. A valid/ID shift register matched to
// the gadget latency routes each result back to its originator.
module hpc1_or_arbiter #(
    parameter int SEC_ORDER = 2,
    parameter int NREQ      = 4,
    parameter int RND_W     = 6,
    parameter int G_LAT     = 2
) (
    input  logic             clk,
    input  logic             rst,
    hpc1_or_arbiter_if.slave bus
);
    localparam int D   = SEC_ORDER + 1;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One issue-register stage plus G_LAT gadget stages
    localparam int TD  = G_LAT + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_QUIET = 2'd2;

    logic [IDW-1:0]   r_ptr;
    logic [D-1:0]     r_g_ina;
    logic [D-1:0]     r_g_inb;
    logic [RND_W-1:0] r_g_rnd;
    logic [TD-1:0]    r_trk_v;
    logic [IDW-1:0]   r_trk_id [TD];

    logic [D-1:0]     w_a_lane [NREQ];
    logic [D-1:0]     w_b_lane [NREQ];
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_scan;
    logic [IDW-1:0]   w_ptr_nxt;
    logic             w_any;
    logic             w_issue;
    logic [1:0]       w_state;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_a_lane[gi] = bus.req_a[gi*D +: D];
            assign w_b_lane[gi] = bus.req_b[gi*D +: D];
        end
    endgenerate

    // Winner: first requester at or above r_ptr, wrapping (scanned backwards so the nearest wins)
    always_comb begin
        w_win  = r_ptr;
        w_any  = 1'b0;
        w_scan = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan = IDW'((int'(r_ptr) + k) % NREQ);
            if (bus.req_valid[w_scan]) begin
                w_win = w_scan;
                w_any = 1'b1;
            end
        end
    end

    // Issue needs a request, a fresh randomness word and no drain; reset masks the handshake
    assign w_issue   = ~rst & bus.rnd_valid & ~bus.drain & w_any;
    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    // One-hot grant to the winner in the issue cycle only
    always_comb begin
        bus.req_ready = '0;
        if (w_issue) begin
            bus.req_ready[w_win] = 1'b1;
        end
    end

    assign bus.rnd_ready = w_issue;

    // Issue stage: capture winner's shares and the randomness word, zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_g_ina <= '0;
            r_g_inb <= '0;
            r_g_rnd <= '0;
        end else if (w_issue) begin
            r_ptr   <= w_ptr_nxt;
            r_g_ina <= w_a_lane[w_win];
            r_g_inb <= w_b_lane[w_win];
            r_g_rnd <= bus.rnd_in;
        end else begin
            r_g_ina <= '0;
            r_g_inb <= '0;
            r_g_rnd <= '0;
        end
    end

    assign bus.g_ina = r_g_ina;
    assign bus.g_inb = r_g_inb;
    assign bus.g_rnd = r_g_rnd;

    // Tracking pipeline: shifts every cycle, no stall, aligned with the gadget output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trk_v <= '0;
            for (int k = 0; k < TD; k++) begin
                r_trk_id[k] <= '0;
            end
        end else begin
            r_trk_v     <= {r_trk_v[TD-2:0], w_issue};
            r_trk_id[0] <= w_win;
            for (int k = 1; k < TD; k++) begin
                r_trk_id[k] <= r_trk_id[k-1];
            end
        end
    end

    // Response: route the gadget output to the owner, gate the data bus to zero otherwise
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (r_trk_v[TD-1]) begin
            bus.rsp_valid[r_trk_id[TD-1]] = 1'b1;
            bus.rsp_data                  = bus.g_out;
        end
    end

    // Operating state decoded from drain and pipeline occupancy
    always_comb begin
        if (!bus.drain) begin
            w_state = ST_RUN;
        end else if (|r_trk_v) begin
            w_state = ST_DRAIN;
        end else begin
            w_state = ST_QUIET;
        end
    end

    assign bus.idle = (w_state == ST_QUIET);
endmodule

// File: doc/hpc1_or_arbiter.md
Name: hpc1_or_arbiter

Overview:
- Shares one pipelined HPC1 masked-OR gadget instance (pipeline=1) between NREQ requesters, using round-robin arbitration.
- Registers the selected operand shares and one fresh randomness word into an issue stage, then feeds the gadget.
- Tracks each in-flight operation with a valid/ID shift register and returns the masked result to its originator after a fixed latency.
- Provides a drain/quiesce control so the masked-logic datapath can be emptied before reconfiguration or PRNG reseed.

Parameters:
- SEC_ORDER, 2, masking order; D = SEC_ORDER+1 shares per operand.
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ).
- RND_W, 6, randomness bits consumed per gadget invocation (refresh + DOM multiply bits for D).
- G_LAT, 2, gadget latency in cycles from gadget inputs to g_out.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*D  operand A shares; requester i occupies bits [i*D +: D].
- req_b  in  NREQ*D  operand B shares; same packing as req_a.
- rnd_valid  in  1  fresh randomness available.
- rnd_in  in  RND_W  randomness word.
- rnd_ready  out  1  randomness word consumed this cycle.
- drain  in  1  level; stops new issues while high.
- idle  out  1  no operation in flight and drain high.
- g_ina  out  D  to gadget ina (registered).
- g_inb  out  D  to gadget inb (registered).
- g_rnd  out  RND_W  to gadget rnd (registered).
- g_out  in  D  from gadget outt.
- rsp_valid  out  NREQ  one-cycle pulse to the owning requester.
- rsp_data  out  D  result shares, shared bus, valid when any rsp_valid bit is set.

Behaviour:
- Issue condition: issue = rnd_valid & ~drain & (|req_valid). The winner w is the first i with req_valid[i], searching from pointer ptr upward with wrap-around.
- On issue: req_ready[w]=1 and rnd_ready=1 combinationally, same cycle; all other ready bits are 0. req_ready and rnd_ready are never asserted without issue. A randomness word is consumed exactly once and never reused.
- Issue stage: on issue, registers g_ina<=req_a[w], g_inb<=req_b[w], g_rnd<=rnd_in. On non-issue cycles all three load all-zero, so no stale shares or randomness are held.
- Round robin: ptr<=(w+1) mod NREQ on issue; otherwise ptr holds. A requester holding req_valid high gets at most one grant per NREQ issues while others are requesting.
- Tracking pipeline: depth G_LAT+1 of {v, id}. Stage 0 loads {issue, w}, and the entries shift every cycle unconditionally. There is no stall and no response backpressure; requesters must sink a response in any cycle.
- Response: when the last stage has v=1, rsp_valid[id]=1 and rsp_data=g_out in that same cycle. Otherwise rsp_valid=0 and rsp_data=0, with rsp_data gated to zero when not valid.
- Latency: handshake in cycle t gives rsp_valid in cycle t+G_LAT+1 (3 cycles by default). Throughput is one issue per cycle.
- States: RUN (drain=0) and DRAIN (drain=1, tracking pipeline non-empty) and QUIET (drain=1, pipeline empty; idle=1).
  - drain deassertion returns to RUN on the next cycle.
  - Operations already in flight complete normally during DRAIN.
- Simultaneous events:
  - drain rising in the same cycle as request/randomness: no issue that cycle.
  - rnd_valid=0: no issue; requests wait with no timeout.
- Reset (asynchronous, any time, including mid-operation): ptr=0, tracking pipeline cleared, g_ina/g_inb/g_rnd=0, rsp_valid=0, rsp_data=0, req_ready=0, rnd_ready=0. idle is 1 if drain=1. In-flight results are discarded, never delivered.
- Width rules: D share lanes are passed through untouched; the arbiter performs no recombination or unmasking of shares.

Test Plan:
- Single request: NREQ=4, req_valid=0001, rnd_valid=1, shares a=3'b101, b=3'b011 (unmasked 0 and 0) -> req_ready=0001, rnd_ready pulses once; rsp_valid=0001 exactly 3 cycles later; XOR of rsp_data equals the OR of the unmasked inputs.
- Contention: req_valid=1111 held for 8 cycles, rnd_valid=1 -> grant order 0,1,2,3,0,1,2,3; responses arrive in the same order at 3-cycle offset; 8 distinct randomness words consumed.
- Randomness starvation: req_valid=0010, rnd_valid low for 5 cycles -> no ready, g_* stay 0; the grant occurs in the first cycle rnd_valid=1.
- Drain: 3 back-to-back issues, then drain=1 -> no further grants; the 3 responses complete; idle=1 one cycle after the last rsp_valid; releasing drain resumes issue.
- Reset mid-flight: assert rst 1 cycle after two issues -> all outputs 0 immediately, no rsp_valid after release, ptr restarts at requester 0.
- Exhaustive functional: for each of the 4 unmasked input pairs with random masks, XOR of rsp_data equals a|b over 1000 randomized operations.
